morphle_cfg_loader: RTL
=======================

# morphle_cfg_loader

Wishbone-driven configuration sequencer sitting directly upstream of the Morphle Logic cell block. It replaces hand-toggling of the block's configuration pins from the logic analyzer. Software pushes one 16-bit column word per write into a small FIFO. The block then presents each word on the block's `cbitin` lines, emits one clean `confclk` pulse per word, optionally captures the `cbitout` shifted out of the bottom row, and drives the block-wide `reset`.

## Interface
Parameters:
- `BLOCKWIDTH`, 16, columns in the cell block; width of the configuration word.
- `FIFO_DEPTH`, 4, configuration word FIFO entries; power of two, ≥2.
- `PULSE_CYCLES`, 2, `wb_clk_i` cycles for each of the `confclk` high and low phases; ≥1.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte selects. Honoured for CTRL only; DATA requires `sel[1:0]`=11, otherwise the write is ignored.
- `wbs_adr_i`  in  32  only bits [3:2] are decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `cfg_reset`  out  1  to block `reset`.
- `cfg_clk`  out  1  to block `confclk`.
- `cfg_bits`  out  BLOCKWIDTH  to block `cbitin`.
- `cfg_bits_ret`  in  BLOCKWIDTH  from block `cbitout`.

## Operation
Register map (word offsets):
- 0x0 CTRL:
  - bit0 `cfg_reset` (R/W, reset 1).
  - bit1 FIFO flush (write-1, self-clearing).
  - bit2 word-counter clear (write-1, self-clearing).
- 0x4 STATUS (RO except bit7):
  - [2:0] FIFO level.
  - bit4 busy (FSM not IDLE).
  - bit5 full.
  - bit6 empty.
  - bit7 overflow, sticky; write 1 to clear.
  - [31:16] words shifted.
- 0x8 DATA (WO): write pushes `wbs_dat_i[BLOCKWIDTH-1:0]`. A push while full is dropped and sets overflow. Reads return 0.
- 0xC READBACK (RO): last captured `cfg_bits_ret`, zero-extended.

Wishbone behaviour:
- `ack` = `valid & !ack`, registered. Every access completes in exactly one wait cycle.
- A write takes effect on the same edge that raises `ack`.

Sequencer FSM:
- IDLE: if FIFO non-empty, pop the head into `cfg_bits` and go to SETUP.
- SETUP: 1 cycle, `cfg_clk`=0. Then go to HIGH.
- HIGH: `cfg_clk`=1 for PULSE_CYCLES cycles. Then go to LOW.
- LOW: `cfg_clk`=0 for PULSE_CYCLES cycles. On the last LOW cycle:
  - capture `cfg_bits_ret` into READBACK;
  - increment the word counter (16-bit, wraps 0xFFFF→0);
  - pop the next word and go to SETUP if the FIFO is non-empty, else go to IDLE.
- The FSM runs independently of `cfg_reset`.

Boundary conditions:
- `cfg_bits` holds its last value in IDLE.
- Push and pop on the same edge while full: the push is accepted, the level is unchanged, and no overflow is flagged.
- Flush during HIGH/LOW: the word in flight completes its pulse; the queued words are discarded.
- A counter-clear coinciding with an increment: the counter reads 0.

## Timing
- All outputs are registered.
- Reset values:
  - `cfg_reset`=1;
  - `cfg_clk`=0;
  - `cfg_bits`=0;
  - `wbs_ack_o`=0;
  - `wbs_dat_o`=0;
  - FIFO empty;
  - counter, overflow and READBACK 0.
- Asserting `wb_rst_ni` mid-pulse forces `cfg_clk` low immediately (asynchronously).
- DATA write into an empty FIFO with the FSM in IDLE, pushed on edge N:
  - `cfg_bits` is valid from edge N+1;
  - `cfg_clk` rises at edge N+2 and falls at edge N+2+PULSE_CYCLES.
- `cfg_bits` is stable ≥1 cycle before and throughout the `cfg_clk` high phase.
- Back-to-back word period is 1+2·PULSE_CYCLES cycles (5 at the defaults).

## Configuration
- `MORPHLE_CFG_READBACK_EN` defined: the READBACK register and its capture logic are built as described.
- Undefined: READBACK reads 0, `cfg_bits_ret` is unused, and no capture flops are instantiated. Everything else is unchanged.

## Test plan
- Reset: hold `wb_rst_ni`=0, then release.
  - Expect `cfg_reset`=1, `cfg_clk`=0, STATUS=0x0000_0040.
- Single word: write CTRL=0, then DATA=0xA5C3.
  - Expect `cfg_bits`=0xA5C3 one edge after ack.
  - Expect one `cfg_clk` pulse, 2 cycles high.
  - Expect STATUS[31:16]=1 and busy=0 after 5 cycles.
- Burst/overflow: write DATA 6 times back-to-back while the FSM is stalled by prior words.
  - Expect exactly 5 pulses.
  - Expect the overflow bit set.
  - Writing STATUS=0x80 clears overflow.
- Flush mid-pulse: push 4 words, write CTRL bit1 during the first HIGH phase.
  - Expect only 1 pulse total, FIFO empty, counter=1.
- Readback (macro defined): drive `cfg_bits_ret`=0x1234 and push one word.
  - Expect READBACK=0x0000_1234 after the pulse.
  - Without the macro, READBACK=0.
- Async reset mid-pulse: drop `wb_rst_ni` during HIGH.
  - Expect `cfg_clk`=0 and `cfg_reset`=1 without waiting for a clock edge.
  - Expect FIFO empty after release.

Source files
------------

// File: rtl/morphle_cfg_loader.sv
// Wishbone-fed configuration sequencer that drives the Morphle Logic block configuration pins.
// Defining MORPHLE_CFG_READBACK_EN builds the READBACK capture of cfg_bits_ret.
module morphle_cfg_loader #(
  parameter int BLOCKWIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_reset,
  output logic                  cfg_clk,
  output logic [BLOCKWIDTH-1:0] cfg_bits,
  input  logic [BLOCKWIDTH-1:0] cfg_bits_ret
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_CNT = PW'(PULSE_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LOW   = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_RDBK   = 2'd3;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_cnt;
  logic [15:0]           r_words;
  logic                  r_ovf;
  logic [BLOCKWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;

  logic                  w_acc;
  logic                  w_wr;
  logic [1:0]            w_adr;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_cnt_clr;
  logic                  w_ovf_clr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_last;
  logic                  w_word_done;
  logic [BLOCKWIDTH-1:0] w_head;
  logic [BLOCKWIDTH-1:0] w_readback;
  logic [31:0]           w_status;
  logic [31:0]           w_rd_data;
  logic                  w_unused_bus;

  // One access per two cycles: ack blocks a second acceptance of the same strobe.
  assign w_acc      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign w_wr       = w_acc & wbs_we_i;
  assign w_adr      = wbs_adr_i[3:2];
  assign w_push_req = w_wr & (w_adr == A_DATA) & (wbs_sel_i[1:0] == 2'b11);
  assign w_flush    = w_wr & (w_adr == A_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
  assign w_cnt_clr  = w_wr & (w_adr == A_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
  assign w_ovf_clr  = w_wr & (w_adr == A_STATUS) & wbs_dat_i[7];
  assign w_unused_bus = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == DEPTH_L);
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_word_done = (r_state == S_LOW) & w_last;
  assign w_pop       = ((r_state == S_IDLE) | w_word_done) & ~w_empty;
  // A slot freed by a pop on the same edge makes room for the push.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wbs_dat_i[BLOCKWIDTH-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      cfg_clk  <= 1'b0;
      cfg_bits <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            cfg_bits <= w_head;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          cfg_clk <= 1'b1;
          r_state <= S_HIGH;
        end
        S_HIGH: begin
          if (w_last) begin
            r_cnt   <= '0;
            cfg_clk <= 1'b0;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        default: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!w_empty) begin
              cfg_bits <= w_head;
              r_state  <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_words <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // Clear dominates a coincident increment.
      if (w_cnt_clr) begin
        r_words <= '0;
      end else if (w_word_done) begin
        r_words <= r_words + 16'd1;
      end
      if (w_push_req & w_full & ~w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef MORPHLE_CFG_READBACK_EN
  logic [BLOCKWIDTH-1:0] r_readback;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_readback <= '0;
    end else if (w_word_done) begin
      r_readback <= cfg_bits_ret;
    end
  end

  assign w_readback = r_readback;
`else
  logic w_unused_ret;

  assign w_readback   = '0;
  assign w_unused_ret = ^cfg_bits_ret;
`endif

  always_comb begin
    w_status        = '0;
    w_status[2:0]   = 3'(r_level);
    w_status[4]     = (r_state != S_IDLE);
    w_status[5]     = w_full;
    w_status[6]     = w_empty;
    w_status[7]     = r_ovf;
    w_status[31:16] = r_words;
  end

  always_comb begin
    case (w_adr)
      A_CTRL:   w_rd_data = {31'd0, cfg_reset};
      A_STATUS: w_rd_data = w_status;
      A_DATA:   w_rd_data = '0;
      default:  w_rd_data = 32'(w_readback);
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      cfg_reset <= 1'b1;
    end else begin
      wbs_ack_o <= w_acc;
      if (w_acc) begin
        wbs_dat_o <= wbs_we_i ? 32'd0 : w_rd_data;
      end
      if (w_wr && (w_adr == A_CTRL) && wbs_sel_i[0]) begin
        cfg_reset <= wbs_dat_i[0];
      end
    end
  end

endmodule
